branch_history_predictor: RTL and testbench
===========================================

BRANCH_HISTORY_PREDICTOR -- requirements
Module: branch_history_predictor

Interface
REQ-001 Parameter ENTRIES, default 64: number of pattern-history-table (PHT) entries; SHALL be a power of two, 4..1024; IDX_W = log2(ENTRIES).
REQ-002 Parameter CNT_W, default 2: saturating-counter width; legal range 1..4.
REQ-003 Parameter GHR_W, default 6: global-history width; SHALL satisfy 1 <= GHR_W <= IDX_W.
REQ-004 Parameter MODE, default 1: 0 = bimodal (PC-indexed), 1 = gshare (PC XOR history).
REQ-005 Parameter PC_W, default 30: word-address width (byte address bits [31:2]).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 proc_reset  input  1  asynchronous, active-high reset.
REQ-008 stall  input  1  freezes all state when high; outputs remain combinationally valid.
REQ-009 lookup_valid  input  1  fetch-stage instruction valid this cycle.
REQ-010 lookup_is_branch  input  1  fetched instruction is a conditional branch (BEQ/BNE).
REQ-011 lookup_pc  input  PC_W  word address of the fetched instruction.
REQ-012 pred_taken  output  1  predicted direction, combinational from the lookup inputs in the same cycle.
REQ-013 pred_idx  output  IDX_W  PHT index used; carried down the pipeline for update.
REQ-014 pred_ghr  output  GHR_W  GHR value before this lookup's speculative shift; carried for repair.
REQ-015 update_valid  input  1  a branch resolved in ID this cycle.
REQ-016 update_idx  input  IDX_W  pred_idx captured at that branch's lookup.
REQ-017 update_taken  input  1  actual resolved direction.
REQ-018 update_mispredict  input  1  resolved direction differs from prediction.
REQ-019 update_ghr  input  GHR_W  pred_ghr captured at that branch's lookup.
REQ-020 mispredict_count  output  16  saturating count of mispredicted updates.

Function
REQ-021 Index SHALL be lookup_pc[IDX_W-1:0] in MODE 0, and lookup_pc[IDX_W-1:0] XOR zero-extended GHR in MODE 1.
REQ-022 pred_taken SHALL be the MSB of PHT[pred_idx] when lookup_valid && lookup_is_branch, else 0.
REQ-023 Zero-cycle prediction latency; PHT read is asynchronous with no write-to-read bypass: a same-cycle update to the looked-up index is not visible until the next cycle.
REQ-024 On update_valid && !stall, PHT[update_idx] SHALL increment if update_taken and decrement otherwise, saturating at 2^CNT_W-1 and 0.
REQ-025 On lookup_valid && lookup_is_branch && !stall && !(update_valid && update_mispredict), GHR <= {GHR[GHR_W-2:0], pred_taken} (speculative shift; for GHR_W=1, GHR <= pred_taken).
REQ-026 On update_valid && update_mispredict && !stall, GHR <= {update_ghr[GHR_W-2:0], update_taken}; repair SHALL take priority over the speculative shift in the same cycle, and that cycle's lookup SHALL be treated as flushed.
REQ-027 Correctly predicted updates SHALL NOT modify GHR.
REQ-028 mispredict_count SHALL increment on each update_valid && update_mispredict && !stall, and hold at 16'hFFFF.
REQ-029 In MODE 0, GHR SHALL still be maintained and reported on pred_ghr but SHALL NOT affect indexing.
REQ-030 While stall is high, PHT, GHR and mispredict_count SHALL hold; pred_* outputs SHALL track the current inputs.

Reset
REQ-031 Asserting proc_reset SHALL immediately set every PHT entry to weakly-not-taken, 2^(CNT_W-1)-1 (01 for CNT_W=2; 0 for CNT_W=1), GHR to 0, and mispredict_count to 0.
REQ-032 During reset, pred_taken SHALL read 0; any update arriving in the reset-release cycle is applied on the first clock edge after deassertion.

Structure
REQ-033 A shared package bp_pkg SHALL hold the MODE encodings (BP_BIMODAL=0, BP_GSHARE=1) and the counter-init and saturate helper functions.
REQ-034 The GHR with its shift/repair logic SHALL be a sub-module, bp_ghr; the PHT array and counters stay in the top module.

Verification
REQ-035 Reset, then lookup pc=0x10 branch (MODE 0) -> pred_taken=0, pred_idx=0x10, mispredict_count=0.
REQ-036 Two taken updates to idx 5 (CNT_W=2), then lookup idx 5 -> counter 01->10->11, pred_taken=1; a third taken update holds the counter at 11.
REQ-037 MODE 1, GHR=6'b000011, lookup pc=0x00 predicted not-taken -> pred_idx=0x03, pred_ghr=0x03, GHR becomes 0x06 next cycle.
REQ-038 Same cycle: lookup branch plus update_mispredict with update_ghr=0x0A, update_taken=1 -> GHR=0x15, speculative shift discarded, mispredict_count +1.
REQ-039 Same-cycle update and lookup on idx 7, counter 01, update taken -> pred_taken=0 this cycle, 1 the next cycle.
REQ-040 stall=1 with update_valid and a branch lookup for 3 cycles -> PHT, GHR and count unchanged; proc_reset mid-run -> all entries return to 01 asynchronously.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: mode encodings and counter helpers.
// Purely combinational helpers; no state lives here.
// No flow control; callers decide when the results are applied.
package bp_pkg;

    // Indexing modes for the pattern history table
    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Widest saturating counter the helpers below are written for
    localparam int BP_CNT_W_MAX = 4;

    // Weakly-not-taken starting value for a counter of width w: 2^(w-1)-1
    function automatic logic [BP_CNT_W_MAX-1:0] cnt_init(input int unsigned w);
        logic [BP_CNT_W_MAX:0] v;
        v = (5'd1 << (w - 1)) - 5'd1;
        return v[BP_CNT_W_MAX-1:0];
    endfunction

    // One saturating step of a w-bit counter: up when 'up', else down
    function automatic logic [BP_CNT_W_MAX-1:0] cnt_sat_step(
        input logic [BP_CNT_W_MAX-1:0] cnt,
        input logic                    up,
        input int unsigned             w
    );
        logic [BP_CNT_W_MAX:0] lim;
        lim = (5'd1 << w) - 5'd1;
        if (up) begin
            return ({1'b0, cnt} == lim) ? cnt : cnt + 4'd1;
        end
        return (cnt == 4'd0) ? cnt : cnt - 4'd1;
    endfunction

endpackage

// File: rtl/branch_history_predictor_if.sv
// Lookup / update / status bundle between the pipeline and the branch predictor.
// No latency of its own; pred_* are combinational from the lookup fields.
// stall freezes predictor state; the master keeps driving lookups while stalled.
interface branch_history_predictor_if #(
    parameter int PC_W  = 30,
    parameter int IDX_W = 6,
    parameter int GHR_W = 6
);
    logic             stall;
    logic             lookup_valid;
    logic             lookup_is_branch;
    logic [PC_W-1:0]  lookup_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic [GHR_W-1:0] pred_ghr;
    logic             update_valid;
    logic [IDX_W-1:0] update_idx;
    logic             update_taken;
    logic             update_mispredict;
    logic [GHR_W-1:0] update_ghr;
    logic [15:0]      mispredict_count;

    // Pipeline side: drives fetch lookups and ID-stage resolutions
    modport master (
        output stall, lookup_valid, lookup_is_branch, lookup_pc,
        output update_valid, update_idx, update_taken, update_mispredict, update_ghr,
        input  pred_taken, pred_idx, pred_ghr, mispredict_count
    );

    // Predictor side
    modport slave (
        input  stall, lookup_valid, lookup_is_branch, lookup_pc,
        input  update_valid, update_idx, update_taken, update_mispredict, update_ghr,
        output pred_taken, pred_idx, pred_ghr, mispredict_count
    );
endinterface

// File: rtl/bp_ghr.sv
// Global history register with speculative shift and mispredict repair.
// One-cycle update; the current value is visible on ghr_o the cycle it is held.
// stall_i holds the register; repair wins over a same-cycle speculative shift.
module bp_ghr
    import bp_pkg::*;
#(
    parameter int GHR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             spec_vld_i,
    input  logic             spec_bit_i,
    input  logic             repair_vld_i,
    input  logic [GHR_W-1:0] repair_ghr_i,
    input  logic             repair_bit_i,
    output logic [GHR_W-1:0] ghr_o
);

    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [GHR_W-1:0] shifted_spec;
    logic [GHR_W-1:0] shifted_repair;

    // A one-bit history is simply replaced; wider ones shift the new outcome in at bit 0
    generate
        if (GHR_W == 1) begin : g_one_bit
            logic unused_repair_ghr;
            assign shifted_spec      = spec_bit_i;
            assign shifted_repair    = repair_bit_i;
            assign unused_repair_ghr = repair_ghr_i[0];
        end else begin : g_multi_bit
            logic unused_repair_msb;
            assign shifted_spec      = {ghr_q[GHR_W-2:0], spec_bit_i};
            assign shifted_repair    = {repair_ghr_i[GHR_W-2:0], repair_bit_i};
            assign unused_repair_msb = repair_ghr_i[GHR_W-1];
        end
    endgenerate

    // Next history: repair from the resolved branch first, else speculative shift, else hold
    always_comb begin
        ghr_d = ghr_q;
        if (!stall_i) begin
            if (repair_vld_i) begin
                ghr_d = shifted_repair;
            end else if (spec_vld_i) begin
                ghr_d = shifted_spec;
            end
        end
    end

    // History register, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_o = ghr_q;

endmodule

// File: rtl/branch_history_predictor.sv
// Bimodal / gshare direction predictor: PHT of saturating counters plus global history.
// Zero-cycle prediction from an asynchronous PHT read; updates land on the next edge.
// stall freezes PHT, history and mispredict counter; predictions keep tracking inputs.
module branch_history_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 6,
    parameter int MODE    = BP_GSHARE,
    parameter int PC_W    = 30
) (
    input  logic                         clk,
    input  logic                         proc_reset,
    branch_history_predictor_if.slave    bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

    logic [CNT_W-1:0] pht_q [ENTRIES];
    logic [CNT_W-1:0] upd_cnt_d;
    logic [IDX_W-1:0] lookup_idx;
    logic [GHR_W-1:0] ghr;
    logic             lookup_br;
    logic             pred_taken;
    logic             pht_upd;
    logic             repair;
    logic [15:0]      mcnt_q;
    logic [15:0]      mcnt_d;
    logic             unused_pc_hi;

    // Only the low IDX_W bits of the word address take part in indexing
    assign unused_pc_hi = ^bus.lookup_pc[PC_W-1:IDX_W];

    assign lookup_br = bus.lookup_valid & bus.lookup_is_branch;
    assign pht_upd   = bus.update_valid & ~bus.stall;
    assign repair    = bus.update_valid & bus.update_mispredict & ~bus.stall;

    // Table index: raw PC bits, or PC bits folded with the zero-extended history in gshare
    always_comb begin
        lookup_idx = bus.lookup_pc[IDX_W-1:0];
        if (MODE == BP_GSHARE) begin
            lookup_idx = bus.lookup_pc[IDX_W-1:0] ^ IDX_W'(ghr);
        end
    end

    // Prediction is the counter MSB, forced low for non-branches
    assign pred_taken = lookup_br & pht_q[lookup_idx][CNT_W-1];

    // Saturating step for the entry being trained this cycle
    always_comb begin
        upd_cnt_d = CNT_W'(cnt_sat_step(4'(pht_q[bus.update_idx]), bus.update_taken, CNT_W));
    end

    // Pattern history table; the read above sees the old value on a same-cycle write
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CNT_INIT;
            end
        end else if (pht_upd) begin
            pht_q[bus.update_idx] <= upd_cnt_d;
        end
    end

    // Global history; a repairing update flushes this cycle's lookup from the history
    bp_ghr #(
        .GHR_W (GHR_W)
    ) u_ghr (
        .clk          (clk),
        .rst          (proc_reset),
        .stall_i      (bus.stall),
        .spec_vld_i   (lookup_br),
        .spec_bit_i   (pred_taken),
        .repair_vld_i (bus.update_valid & bus.update_mispredict),
        .repair_ghr_i (bus.update_ghr),
        .repair_bit_i (bus.update_taken),
        .ghr_o        (ghr)
    );

    // Mispredict counter next value, sticking at all-ones
    always_comb begin
        mcnt_d = mcnt_q;
        if (repair && (mcnt_q != 16'hFFFF)) begin
            mcnt_d = mcnt_q + 16'd1;
        end
    end

    // Mispredict counter register
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            mcnt_q <= '0;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign bus.pred_taken       = pred_taken;
    assign bus.pred_idx         = lookup_idx;
    assign bus.pred_ghr         = ghr;
    assign bus.mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Drives one bimodal and one gshare predictor with identical stimulus and
// checks both against an integer-level model of the predictor rules.
module tb_branch_history_predictor;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int GHR_W   = 6;
    localparam int PC_W    = 30;
    localparam int IDX_W   = 6;

    logic             clk;
    logic             proc_reset;
    logic             stall;
    logic             lookup_valid;
    logic             lookup_is_branch;
    logic [PC_W-1:0]  lookup_pc;
    logic             update_valid;
    logic [IDX_W-1:0] update_idx;
    logic             update_taken;
    logic             update_mispredict;
    logic [GHR_W-1:0] update_ghr;

    int total = 0;
    int bad   = 0;

    // Model state: [0] bimodal instance, [1] gshare instance
    int pht_m [2][ENTRIES];
    int ghr_m [2];
    int cnt_m [2];

    branch_history_predictor_if #(.PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W)) bif0 ();
    branch_history_predictor_if #(.PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W)) bif1 ();

    assign bif0.stall             = stall;
    assign bif0.lookup_valid      = lookup_valid;
    assign bif0.lookup_is_branch  = lookup_is_branch;
    assign bif0.lookup_pc         = lookup_pc;
    assign bif0.update_valid      = update_valid;
    assign bif0.update_idx        = update_idx;
    assign bif0.update_taken      = update_taken;
    assign bif0.update_mispredict = update_mispredict;
    assign bif0.update_ghr        = update_ghr;
    assign bif1.stall             = stall;
    assign bif1.lookup_valid      = lookup_valid;
    assign bif1.lookup_is_branch  = lookup_is_branch;
    assign bif1.lookup_pc         = lookup_pc;
    assign bif1.update_valid      = update_valid;
    assign bif1.update_idx        = update_idx;
    assign bif1.update_taken      = update_taken;
    assign bif1.update_mispredict = update_mispredict;
    assign bif1.update_ghr        = update_ghr;

    branch_history_predictor #(
        .ENTRIES(ENTRIES), .CNT_W(CNT_W), .GHR_W(GHR_W), .MODE(0), .PC_W(PC_W)
    ) dut0 (
        .clk(clk), .proc_reset(proc_reset), .bus(bif0)
    );

    branch_history_predictor #(
        .ENTRIES(ENTRIES), .CNT_W(CNT_W), .GHR_W(GHR_W), .MODE(1), .PC_W(PC_W)
    ) dut1 (
        .clk(clk), .proc_reset(proc_reset), .bus(bif1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, summary total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < ENTRIES; i++) pht_m[m][i] = (1 << (CNT_W - 1)) - 1;
            ghr_m[m] = 0;
            cnt_m[m] = 0;
        end
    endtask

    function automatic int m_idx(int m);
        int lo;
        lo = int'(lookup_pc) % ENTRIES;
        return (m == 0) ? lo : (lo ^ ghr_m[m]);
    endfunction

    function automatic bit m_pred(int m);
        if (!(lookup_valid && lookup_is_branch)) return 1'b0;
        return pht_m[m][m_idx(m)] >= (1 << (CNT_W - 1));
    endfunction

    // Applies what the next rising edge does, using the inputs as they stand now
    task automatic model_edge();
        bit p [2];
        if (proc_reset) begin
            model_reset();
            return;
        end
        if (stall) return;
        for (int m = 0; m < 2; m++) p[m] = m_pred(m);
        for (int m = 0; m < 2; m++) begin
            if (update_valid) begin
                if (update_taken) begin
                    if (pht_m[m][update_idx] < (1 << CNT_W) - 1) pht_m[m][update_idx]++;
                end else if (pht_m[m][update_idx] > 0) begin
                    pht_m[m][update_idx]--;
                end
            end
            if (update_valid && update_mispredict) begin
                ghr_m[m] = (int'(update_ghr) * 2 + int'(update_taken)) % (1 << GHR_W);
                if (cnt_m[m] < 65535) cnt_m[m]++;
            end else if (lookup_valid && lookup_is_branch) begin
                ghr_m[m] = (ghr_m[m] * 2 + int'(p[m])) % (1 << GHR_W);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        stall             = 1'b0;
        lookup_valid      = 1'b0;
        lookup_is_branch  = 1'b0;
        lookup_pc         = '0;
        update_valid      = 1'b0;
        update_idx        = '0;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
        update_ghr        = '0;
    endtask

    task automatic lookup(input int pc);
        lookup_valid     = 1'b1;
        lookup_is_branch = 1'b1;
        lookup_pc        = PC_W'(pc);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        lookup('h10);
        proc_reset = 1'b1;
        model_reset();
        #1;
        total++; if (bif0.mispredict_count !== 16'd0) begin bad++; $display("FAIL reset_cnt0: got %0h want 0", bif0.mispredict_count); end
        total++; if (bif1.mispredict_count !== 16'd0) begin bad++; $display("FAIL reset_cnt1: got %0h want 0", bif1.mispredict_count); end
        total++; if (bif0.pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred0: got %b want 0", bif0.pred_taken); end
        total++; if (bif1.pred_ghr !== 6'd0) begin bad++; $display("FAIL reset_ghr1: got %0h want 0", bif1.pred_ghr); end
        @(negedge clk);
        proc_reset = 1'b0;
    endtask

    task automatic test_bimodal_lookup();
        idle();
        lookup('h10);
        #1;
        total++; if (bif0.pred_taken !== 1'b0) begin bad++; $display("FAIL bimodal_pred: got %b want 0", bif0.pred_taken); end
        total++; if (bif0.pred_idx !== 6'h10) begin bad++; $display("FAIL bimodal_idx: got %0h want 10", bif0.pred_idx); end
        total++; if (bif0.mispredict_count !== 16'd0) begin bad++; $display("FAIL bimodal_cnt: got %0h want 0", bif0.mispredict_count); end
        total++; if (bif1.pred_idx !== 6'(m_idx(1))) begin bad++; $display("FAIL gshare_idx0: got %0h want %0h", bif1.pred_idx, m_idx(1)); end
        tick();
    endtask

    task automatic test_saturate();
        idle();
        update_valid = 1'b1; update_idx = 6'd5; update_taken = 1'b1;
        tick();
        tick();
        update_valid = 1'b0;
        lookup(5);
        #1;
        total++; if (bif0.pred_taken !== 1'b1) begin bad++; $display("FAIL sat_two_up: got %b want 1", bif0.pred_taken); end
        total++; if (bif1.pred_taken !== m_pred(1)) begin bad++; $display("FAIL sat_two_up_g: got %b want %b", bif1.pred_taken, m_pred(1)); end
        update_valid = 1'b1; update_taken = 1'b1;
        tick();
        update_taken = 1'b0;
        tick();
        update_valid = 1'b0;
        #1;
        total++; if (bif0.pred_taken !== 1'b1) begin bad++; $display("FAIL sat_hold_11: got %b want 1", bif0.pred_taken); end
        update_valid = 1'b1;
        tick();
        update_valid = 1'b0;
        #1;
        total++; if (bif0.pred_taken !== 1'b0) begin bad++; $display("FAIL sat_down_01: got %b want 0", bif0.pred_taken); end
        total++; if (bif1.pred_taken !== m_pred(1)) begin bad++; $display("FAIL sat_down_g: got %b want %b", bif1.pred_taken, m_pred(1)); end
        tick();
    endtask

    task automatic test_gshare();
        int c_exp;
        idle();
        update_valid = 1'b1; update_mispredict = 1'b1; update_ghr = 6'h01;
        update_taken = 1'b1; update_idx = 6'h3F;
        tick();
        idle();
        lookup(0);
        #1;
        total++; if (bif1.pred_ghr !== 6'h03) begin bad++; $display("FAIL gshare_ghr_pre: got %0h want 03", bif1.pred_ghr); end
        total++; if (bif1.pred_idx !== 6'h03) begin bad++; $display("FAIL gshare_idx: got %0h want 03", bif1.pred_idx); end
        total++; if (bif1.pred_taken !== 1'b0) begin bad++; $display("FAIL gshare_pred: got %b want 0", bif1.pred_taken); end
        c_exp = cnt_m[1];
        total++; if (bif1.mispredict_count !== 16'(c_exp)) begin bad++; $display("FAIL gshare_cnt: got %0d want %0d", bif1.mispredict_count, c_exp); end
        tick();
        idle();
        #1;
        total++; if (bif1.pred_ghr !== 6'h06) begin bad++; $display("FAIL gshare_ghr_shift: got %0h want 06", bif1.pred_ghr); end
    endtask

    task automatic test_repair_priority();
        int c_exp;
        idle();
        lookup(0);
        update_valid = 1'b1; update_mispredict = 1'b1; update_ghr = 6'h0A;
        update_taken = 1'b1; update_idx = 6'h20;
        c_exp = cnt_m[1] + 1;
        tick();
        idle();
        #1;
        total++; if (bif1.pred_ghr !== 6'h15) begin bad++; $display("FAIL repair_ghr1: got %0h want 15", bif1.pred_ghr); end
        total++; if (bif0.pred_ghr !== 6'h15) begin bad++; $display("FAIL repair_ghr0: got %0h want 15", bif0.pred_ghr); end
        total++; if (bif1.mispredict_count !== 16'(c_exp)) begin bad++; $display("FAIL repair_cnt: got %0d want %0d", bif1.mispredict_count, c_exp); end
    endtask

    task automatic test_same_cycle_update();
        idle();
        lookup(7);
        update_valid = 1'b1; update_idx = 6'd7; update_taken = 1'b1;
        #1;
        total++; if (bif0.pred_taken !== 1'b0) begin bad++; $display("FAIL bypass_same: got %b want 0", bif0.pred_taken); end
        tick();
        update_valid = 1'b0;
        #1;
        total++; if (bif0.pred_taken !== 1'b1) begin bad++; $display("FAIL bypass_next: got %b want 1", bif0.pred_taken); end
        total++; if (bif1.pred_taken !== m_pred(1)) begin bad++; $display("FAIL bypass_next_g: got %b want %b", bif1.pred_taken, m_pred(1)); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall             = ($urandom_range(0, 7) == 0);
            lookup_valid      = ($urandom_range(0, 3) != 0);
            lookup_is_branch  = ($urandom_range(0, 2) != 0);
            lookup_pc         = PC_W'($urandom);
            update_valid      = $urandom_range(0, 1) == 1;
            update_idx        = 6'($urandom_range(0, 15));
            update_taken      = $urandom_range(0, 1) == 1;
            update_mispredict = ($urandom_range(0, 3) == 0);
            update_ghr        = 6'($urandom);
            #1;
            total++; if (bif0.pred_taken !== m_pred(0)) begin bad++; $display("FAIL rnd_pred0 @%0d: got %b want %b", n, bif0.pred_taken, m_pred(0)); end
            total++; if (bif1.pred_taken !== m_pred(1)) begin bad++; $display("FAIL rnd_pred1 @%0d: got %b want %b", n, bif1.pred_taken, m_pred(1)); end
            total++; if (bif0.pred_idx !== 6'(m_idx(0))) begin bad++; $display("FAIL rnd_idx0 @%0d: got %0h want %0h", n, bif0.pred_idx, m_idx(0)); end
            total++; if (bif1.pred_idx !== 6'(m_idx(1))) begin bad++; $display("FAIL rnd_idx1 @%0d: got %0h want %0h", n, bif1.pred_idx, m_idx(1)); end
            total++; if (bif0.pred_ghr !== 6'(ghr_m[0])) begin bad++; $display("FAIL rnd_ghr0 @%0d: got %0h want %0h", n, bif0.pred_ghr, ghr_m[0]); end
            total++; if (bif1.pred_ghr !== 6'(ghr_m[1])) begin bad++; $display("FAIL rnd_ghr1 @%0d: got %0h want %0h", n, bif1.pred_ghr, ghr_m[1]); end
            total++; if (bif1.mispredict_count !== 16'(cnt_m[1])) begin bad++; $display("FAIL rnd_cnt1 @%0d: got %0d want %0d", n, bif1.mispredict_count, cnt_m[1]); end
            tick();
        end
    endtask

    task automatic test_stall_and_reset();
        int g_hold;
        int c_hold;
        int taken_seen;
        idle();
        g_hold = ghr_m[1];
        c_hold = cnt_m[1];
        stall = 1'b1;
        update_valid = 1'b1; update_idx = 6'd9; update_taken = 1'b1;
        update_mispredict = 1'b1; update_ghr = 6'h03;
        for (int k = 0; k < 3; k++) begin
            lookup(9 + k);
            #1;
            total++; if (bif0.pred_idx !== 6'(9 + k)) begin bad++; $display("FAIL stall_idx_track %0d: got %0h want %0h", k, bif0.pred_idx, 9 + k); end
            total++; if (bif1.pred_ghr !== 6'(g_hold)) begin bad++; $display("FAIL stall_ghr %0d: got %0h want %0h", k, bif1.pred_ghr, g_hold); end
            total++; if (bif1.mispredict_count !== 16'(c_hold)) begin bad++; $display("FAIL stall_cnt %0d: got %0d want %0d", k, bif1.mispredict_count, c_hold); end
            tick();
        end
        idle();
        lookup(9);
        #1;
        total++; if (bif0.pred_taken !== m_pred(0)) begin bad++; $display("FAIL stall_pht: got %b want %b", bif0.pred_taken, m_pred(0)); end
        // push entry 9 to strongly taken, then reset in the middle of a cycle
        idle();
        update_valid = 1'b1; update_idx = 6'd9; update_taken = 1'b1;
        tick();
        tick();
        idle();
        lookup(9);
        #1;
        total++; if (bif0.pred_taken !== 1'b1) begin bad++; $display("FAIL prereset_pred: got %b want 1", bif0.pred_taken); end
        #2;
        proc_reset = 1'b1;
        model_reset();
        #1;
        total++; if (bif0.pred_taken !== 1'b0) begin bad++; $display("FAIL async_rst_pred: got %b want 0", bif0.pred_taken); end
        total++; if (bif1.mispredict_count !== 16'd0) begin bad++; $display("FAIL async_rst_cnt: got %0d want 0", bif1.mispredict_count); end
        total++; if (bif1.pred_ghr !== 6'd0) begin bad++; $display("FAIL async_rst_ghr: got %0h want 0", bif1.pred_ghr); end
        taken_seen = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            lookup(i);
            #1;
            if (bif0.pred_taken !== 1'b0) taken_seen++;
        end
        total++; if (taken_seen != 0) begin bad++; $display("FAIL rst_all_entries: got %0d taken entries want 0", taken_seen); end
        @(negedge clk);
        idle();
        update_valid = 1'b1; update_idx = 6'd9; update_taken = 1'b1;
        proc_reset = 1'b0;
        tick();
        idle();
        lookup(9);
        #1;
        total++; if (bif0.pred_taken !== 1'b1) begin bad++; $display("FAIL release_update: got %b want 1", bif0.pred_taken); end
        lookup(10);
        update_valid = 1'b1; update_idx = 6'd10; update_taken = 1'b0;
        tick();
        update_valid = 1'b1; update_taken = 1'b1;
        tick();
        update_valid = 1'b0;
        #1;
        total++; if (bif0.pred_taken !== 1'b0) begin bad++; $display("FAIL rst_weak_nt: got %b want 0", bif0.pred_taken); end
        tick();
    endtask

    initial begin
        proc_reset = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_bimodal_lookup();
        test_saturate();
        test_gshare();
        test_repair_priority();
        test_same_cycle_update();
        test_random();
        test_stall_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
